// File: rtl/lin_phy_serdes_pkg.sv
// lin_pkg: shared frame constants and FSM state types for the LIN PHY.
package lin_pkg;
  localparam int FRAME_W = 10;
  localparam logic START_BIT_VAL = 1'b0;
  localparam logic STOP_BIT_VAL = 1'b1;
  localparam int BREAK_BITS_DEF = 11;
  typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA} rx_state_e;
endpackage

// File: rtl/lin_phy_serdes_if.sv
// lin_phy_serdes_if: frame-side handshake plus single-wire bus signals of the LIN PHY.
interface lin_phy_serdes_if;
  import lin_pkg::*;
  logic [FRAME_W-1:0] tx_frame;
  logic tx_valid;
  logic tx_ready;
  logic lin_tx;
  logic lin_rx;
  logic [FRAME_W-1:0] rx_frame;
  logic rx_valid;
  logic rx_frame_err;
  logic bit_err;
  logic break_det;
  logic bus_busy;
  modport master (
    output tx_frame, tx_valid, lin_rx,
    input tx_ready, lin_tx, rx_frame, rx_valid, rx_frame_err, bit_err, break_det, bus_busy
  );
  modport slave (
    input tx_frame, tx_valid, lin_rx,
    output tx_ready, lin_tx, rx_frame, rx_valid, rx_frame_err, bit_err, break_det, bus_busy
  );
endinterface

// File: rtl/lin_bit_rx.sv
// lin_bit_rx: lin_rx synchronizer, mid-bit sampling RX FSM and break detector.
module lin_bit_rx
  import lin_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int BREAK_BITS = BREAK_BITS_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               lin_rx_i,
  output logic               rxs_o,
  output logic [FRAME_W-1:0] rx_frame_o,
  output logic               rx_valid_o,
  output logic               rx_frame_err_o,
  output logic               break_det_o,
  output logic               busy_o
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam int BMAX = BREAK_BITS * CLKS_PER_BIT;
  localparam int BW = $clog2(BMAX + 1);
  localparam logic [BW-1:0] BLIM = BW'(BMAX);
  rx_state_e state_q, state_d;
  logic [2:0] sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] idx_q, idx_d;
  logic [FRAME_W-1:0] shift_q, shift_d, frame_q, frame_d;
  logic valid_q, valid_d, err_q, err_d, brk_q, brk_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic rxs, fall;
  // sync_q[1] is the synchronized line; sync_q[2] is its previous value for edge detection
  assign rxs = sync_q[1];
  assign fall = sync_q[2] & ~sync_q[1];
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    shift_d = shift_q;
    frame_d = frame_q;
    valid_d = 1'b0;
    err_d = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = fall ? CW'(1) : '0;
        state_d = fall ? RX_START : RX_IDLE;
      end
      RX_START: if (cnt_q == HALF) begin
        state_d = (rxs == START_BIT_VAL) ? RX_DATA : RX_IDLE;
        shift_d = {rxs, shift_q[FRAME_W-1:1]};
        idx_d = 4'd1;
        cnt_d = '0;
      end
      RX_DATA: if (cnt_q == LAST) begin
        shift_d = {rxs, shift_q[FRAME_W-1:1]};
        idx_d = idx_q + 1'b1;
        cnt_d = '0;
        if (idx_q == 4'(FRAME_W - 1)) begin
          state_d = RX_IDLE;
          frame_d = shift_d;
          valid_d = 1'b1;
          err_d = rxs != STOP_BIT_VAL;
        end
      end
      default: state_d = RX_IDLE;
    endcase
    bcnt_d = rxs ? '0 : (bcnt_q == BLIM ? bcnt_q : bcnt_q + 1'b1);
    brk_d = !rxs && bcnt_q == BLIM - 1'b1;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '1;
      state_q <= RX_IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      shift_q <= '0;
      frame_q <= '0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
      bcnt_q <= '0;
      brk_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], lin_rx_i};
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      shift_q <= shift_d;
      frame_q <= frame_d;
      valid_q <= valid_d;
      err_q <= err_d;
      bcnt_q <= bcnt_d;
      brk_q <= brk_d;
    end
  end
  assign rxs_o = rxs;
  assign rx_frame_o = frame_q;
  assign rx_valid_o = valid_q;
  assign rx_frame_err_o = err_q;
  assign break_det_o = brk_q;
  assign busy_o = state_q != RX_IDLE;
endmodule

// File: rtl/lin_phy_serdes.sv
// lin_phy_serdes: LIN bit-level serializer with readback bit-error abort, plus the RX/break path.
module lin_phy_serdes
  import lin_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int BREAK_BITS = BREAK_BITS_DEF
) (
  input logic clk,
  input logic reset,
  lin_phy_serdes_if.slave bus
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  tx_state_e state_q, state_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [3:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic lin_tx_q, lin_tx_d, bit_err_q, bit_err_d;
  logic rxs, rx_busy;
  lin_bit_rx #(.CLKS_PER_BIT(CLKS_PER_BIT), .BREAK_BITS(BREAK_BITS)) u_rx (
    .clk           (clk),
    .reset         (reset),
    .lin_rx_i      (bus.lin_rx),
    .rxs_o         (rxs),
    .rx_frame_o    (bus.rx_frame),
    .rx_valid_o    (bus.rx_valid),
    .rx_frame_err_o(bus.rx_frame_err),
    .break_det_o   (bus.break_det),
    .busy_o        (rx_busy)
  );
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    idx_d = idx_q;
    cnt_d = cnt_q + 1'b1;
    lin_tx_d = lin_tx_q;
    bit_err_d = 1'b0;
    case (state_q)
      TX_IDLE: begin
        cnt_d = '0;
        if (bus.tx_valid) begin
          state_d = TX_SHIFT;
          frame_d = bus.tx_frame;
          idx_d = '0;
          lin_tx_d = bus.tx_frame[0];
        end
      end
      TX_SHIFT: begin
        // the error pulse is flagged while still shifting so a coincident tx_valid is refused
        if (bit_err_q) begin
          state_d = TX_IDLE;
          lin_tx_d = 1'b1;
        end else if (cnt_q == HALF && rxs != lin_tx_q) begin
          bit_err_d = 1'b1;
        end else if (cnt_q == LAST) begin
          cnt_d = '0;
          idx_d = idx_q + 1'b1;
          state_d = idx_q == 4'(FRAME_W - 1) ? TX_IDLE : TX_SHIFT;
          lin_tx_d = idx_q == 4'(FRAME_W - 1) ? 1'b1 : frame_q[idx_q + 1'b1];
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= TX_IDLE;
      frame_q <= '0;
      idx_q <= '0;
      cnt_q <= '0;
      lin_tx_q <= 1'b1;
      bit_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      lin_tx_q <= lin_tx_d;
      bit_err_q <= bit_err_d;
    end
  end
  assign bus.tx_ready = state_q == TX_IDLE;
  assign bus.lin_tx = lin_tx_q;
  assign bus.bit_err = bit_err_q;
  assign bus.bus_busy = state_q != TX_IDLE || rx_busy;
endmodule
